// File: rtl/axi_lite_cmd_pkg.sv
// Shared types for the command-driven AXI4-Lite master.
// States, response codes and the command bundle.
package axi_lite_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int CMD_ADDR_W = 32;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
  } cmd_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Turns a valid/ready command stream into single AXI4-Lite
// transactions, one in flight, one response per command.
module axi_lite_cmd_master
  import axi_lite_cmd_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]
    C_M_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_RESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [31:0]                     cmd_wdata,
  input  logic [3:0]                      cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  state_t state, state_n;

  logic [31:0]     tcnt, tcnt_n;
  logic            expire;
  logic            abort;
  logic            aw_ok, w_ok;
  cmd_t            cmd_in;
  logic [AW-1:0]   acc_addr;

  logic [AW-1:0]   awaddr_n, araddr_n;
  logic [DW-1:0]   wdata_n;
  logic [DW/8-1:0] wstrb_n;
  logic            awvalid_n, wvalid_n, bready_n;
  logic            arvalid_n, rready_n;
  logic            rsp_valid_n, rsp_timeout_n;
  logic [31:0]     rsp_rdata_n;
  logic [1:0]      rsp_resp_n;
  logic            cmd_ready_n, busy_n;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign cmd_in = {cmd_write, CMD_ADDR_W'(cmd_addr),
                   cmd_wdata, cmd_wstrb};

  assign acc_addr = C_M_TARGET_SLAVE_BASE_ADDR
                  + AW'(cmd_in.addr);

  assign expire = (TIMEOUT_CYCLES != 0)
               && (tcnt == 32'(TIMEOUT_CYCLES - 1));

  // Next-state, next-output and wait-timer logic.
  always_comb begin
    state_n       = state;
    tcnt_n        = tcnt + 32'd1;
    abort         = 1'b0;
    aw_ok         = 1'b0;
    w_ok          = 1'b0;
    awaddr_n      = M_AXI_AWADDR;
    araddr_n      = M_AXI_ARADDR;
    wdata_n       = M_AXI_WDATA;
    wstrb_n       = M_AXI_WSTRB;
    awvalid_n     = M_AXI_AWVALID;
    wvalid_n      = M_AXI_WVALID;
    bready_n      = M_AXI_BREADY;
    arvalid_n     = M_AXI_ARVALID;
    rready_n      = M_AXI_RREADY;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_resp_n    = rsp_resp;
    rsp_timeout_n = rsp_timeout;

    unique case (state)
      IDLE: begin
        tcnt_n = '0;
        if (cmd_valid && cmd_ready) begin
          if (cmd_in.write) begin
            state_n   = WR_AW_W;
            awaddr_n  = acc_addr;
            wdata_n   = DW'(cmd_in.wdata);
            wstrb_n   = (DW/8)'(cmd_in.wstrb);
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD_AR;
            araddr_n  = acc_addr;
            arvalid_n = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        aw_ok     = !M_AXI_AWVALID || M_AXI_AWREADY;
        w_ok      = !M_AXI_WVALID || M_AXI_WREADY;
        awvalid_n = !aw_ok;
        wvalid_n  = !w_ok;
        if (aw_ok && w_ok) begin
          state_n  = WR_B;
          bready_n = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      WR_B: begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          state_n       = RESP;
          bready_n      = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_resp_n    = M_AXI_BRESP;
          rsp_rdata_n   = '0;
          rsp_timeout_n = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_AR: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          state_n   = RD_R;
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_R: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          state_n       = RESP;
          rready_n      = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_resp_n    = M_AXI_RRESP;
          rsp_rdata_n   = 32'(M_AXI_RDATA);
          rsp_timeout_n = 1'b0;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RESP: begin
        tcnt_n = '0;
        if (rsp_ready) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (abort) begin
      state_n       = RESP;
      awvalid_n     = 1'b0;
      wvalid_n      = 1'b0;
      bready_n      = 1'b0;
      arvalid_n     = 1'b0;
      rready_n      = 1'b0;
      rsp_valid_n   = 1'b1;
      rsp_resp_n    = RESP_SLVERR;
      rsp_rdata_n   = '0;
      rsp_timeout_n = 1'b1;
    end

    if (state_n != state) tcnt_n = '0;

    cmd_ready_n = (state_n == IDLE) && !rsp_valid_n;
    busy_n      = (state_n != IDLE);
  end

  // State and every output register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_RESET) begin
      state         <= IDLE;
      tcnt          <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_timeout   <= 1'b0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      tcnt          <= tcnt_n;
      M_AXI_AWADDR  <= awaddr_n;
      M_AXI_ARADDR  <= araddr_n;
      M_AXI_WDATA   <= wdata_n;
      M_AXI_WSTRB   <= wstrb_n;
      M_AXI_AWVALID <= awvalid_n;
      M_AXI_WVALID  <= wvalid_n;
      M_AXI_BREADY  <= bready_n;
      M_AXI_ARVALID <= arvalid_n;
      M_AXI_RREADY  <= rready_n;
      rsp_valid     <= rsp_valid_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_resp      <= rsp_resp_n;
      rsp_timeout   <= rsp_timeout_n;
      cmd_ready     <= cmd_ready_n;
      busy          <= busy_n;
    end
  end

endmodule
